// File: rtl/xoodyak_squeeze.sv
// Xoodyak Squeeze stage: Up(Cu=0x40) on the post-absorb state, then one
// Down(e,0x00)+Up(0x00) per further output block. The permutation is external
// and is reached through a perm_start / perm_done handshake.
//
// Ports
//   eph1, reset       clock (rising edge), asynchronous active-low reset
//   start             begin squeeze; sampled only while idle
//   sqz_blocks        number of output blocks (0 = no output, no permutation)
//   sqz_last_bytes    valid bytes in the final block (0 or >24 means 24)
//   state_in          post-absorb state, captured on an accepted start
//   sqz_to_permute    state handed to the permutation (always the work register)
//   perm_start        one-cycle permutation request
//   permute_to_sqz    permuted state, valid while perm_done=1
//   perm_done         permutation result valid
//   sqz_data          output block, trailing unused bytes of the final block zeroed
//   sqz_valid/ready   output stream handshake; sqz_last marks the final block
//   squeezed_state    final state, held until the next operation completes
//   sqz_complete      one-cycle pulse at the end of the operation
//   busy              high whenever the controller is not idle
module xoodyak_squeeze #(
  parameter int unsigned STATE_W = 384,
  parameter int unsigned RATE_W  = 192,
  parameter logic [7:0]  CU_SQZ  = 8'h40,
  parameter int unsigned LEN_W   = 8
) (
  input  logic               eph1,
  input  logic               reset,
  input  logic               start,
  input  logic [LEN_W-1:0]   sqz_blocks,
  input  logic [4:0]         sqz_last_bytes,
  input  logic [STATE_W-1:0] state_in,
  output logic [STATE_W-1:0] sqz_to_permute,
  output logic               perm_start,
  input  logic [STATE_W-1:0] permute_to_sqz,
  input  logic               perm_done,
  output logic [RATE_W-1:0]  sqz_data,
  output logic               sqz_valid,
  input  logic               sqz_ready,
  output logic               sqz_last,
  output logic [STATE_W-1:0] squeezed_state,
  output logic               sqz_complete,
  output logic               busy
);

  typedef enum logic [2:0] {IDLE, PREQ, PWAIT, OUT, DONE} state_t;

  localparam int unsigned        RATE_BYTES = RATE_W / 8;
  localparam logic [STATE_W-1:0] CU_MASK    = STATE_W'(CU_SQZ);
  // Down(e,0x00) pads 0x01 into byte 0, i.e. the low bit of the top byte.
  localparam logic [STATE_W-1:0] DOWN_PAD   = STATE_W'(1) << (STATE_W - 8);

  state_t             st;
  logic [STATE_W-1:0] work;
  logic [LEN_W-1:0]   rem;
  logic [4:0]         last_bytes;
  logic [4:0]         lb_norm;

  assign sqz_to_permute = work;
  assign lb_norm = (sqz_last_bytes == 5'd0 || sqz_last_bytes > 5'(RATE_BYTES))
                   ? 5'(RATE_BYTES) : sqz_last_bytes;

  // Rate slice of a state; on the final block, bytes at index >= lb are zeroed.
  function automatic logic [RATE_W-1:0] rate_block(input logic [STATE_W-1:0] s,
                                                   input logic final_blk,
                                                   input logic [4:0] lb);
    logic [RATE_W-1:0] blk;
    int unsigned       lbi;
    blk = s[STATE_W-1 -: RATE_W];
    lbi = 32'(lb);
    for (int unsigned i = 0; i < RATE_BYTES; i++) begin
      if (final_blk && i >= lbi) blk[RATE_W-1-8*i -: 8] = '0;
    end
    return blk;
  endfunction

  always_ff @(posedge eph1 or negedge reset) begin
    if (!reset) begin
      st             <= IDLE;
      work           <= '0;
      rem            <= '0;
      last_bytes     <= '0;
      perm_start     <= 1'b0;
      sqz_data       <= '0;
      sqz_valid      <= 1'b0;
      sqz_last       <= 1'b0;
      squeezed_state <= '0;
      sqz_complete   <= 1'b0;
      busy           <= 1'b0;
    end else begin
      perm_start   <= 1'b0;
      sqz_complete <= 1'b0;
      case (st)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (sqz_blocks == '0) begin
              work         <= state_in;
              st           <= DONE;
              sqz_complete <= 1'b1;
            end else begin
              work       <= state_in ^ CU_MASK;
              rem        <= sqz_blocks;
              last_bytes <= lb_norm;
              st         <= PREQ;
              perm_start <= 1'b1;
            end
          end
        end
        PREQ: st <= PWAIT;
        PWAIT: begin
          if (perm_done) begin
            // Output block is formed from the incoming result so it is
            // registered and valid in the first OUT cycle.
            work      <= permute_to_sqz;
            st        <= OUT;
            sqz_valid <= 1'b1;
            sqz_data  <= rate_block(permute_to_sqz, rem == LEN_W'(1), last_bytes);
            sqz_last  <= (rem == LEN_W'(1));
          end
        end
        OUT: begin
          if (sqz_ready) begin
            sqz_valid <= 1'b0;
            sqz_data  <= '0;
            sqz_last  <= 1'b0;
            if (rem == LEN_W'(1)) begin
              st           <= DONE;
              sqz_complete <= 1'b1;
            end else begin
              rem        <= rem - LEN_W'(1);
              work       <= work ^ DOWN_PAD;
              st         <= PREQ;
              perm_start <= 1'b1;
            end
          end
        end
        DONE: begin
          squeezed_state <= work;
          st             <= IDLE;
          busy           <= 1'b0;
        end
        default: begin
          st   <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xoodyak_squeeze.sv
module tb_xoodyak_squeeze;

  logic         eph1, reset, start;
  logic [7:0]   sqz_blocks;
  logic [4:0]   sqz_last_bytes;
  logic [383:0] state_in, sqz_to_permute, permute_to_sqz, squeezed_state;
  logic         perm_start, perm_done;
  logic [191:0] sqz_data;
  logic         sqz_valid, sqz_ready, sqz_last, sqz_complete, busy;

  xoodyak_squeeze #(.STATE_W(384), .RATE_W(192), .CU_SQZ(8'h40), .LEN_W(8)) dut (
    .eph1(eph1), .reset(reset), .start(start), .sqz_blocks(sqz_blocks),
    .sqz_last_bytes(sqz_last_bytes), .state_in(state_in),
    .sqz_to_permute(sqz_to_permute), .perm_start(perm_start),
    .permute_to_sqz(permute_to_sqz), .perm_done(perm_done),
    .sqz_data(sqz_data), .sqz_valid(sqz_valid), .sqz_ready(sqz_ready),
    .sqz_last(sqz_last), .squeezed_state(squeezed_state),
    .sqz_complete(sqz_complete), .busy(busy)
  );

  initial eph1 = 1'b0;
  always #5 eph1 = ~eph1;

  int checks = 0;
  int failures = 0;

  // Expected traffic from the reference model, observed traffic from the DUT.
  logic [383:0] exp_perm[$], exp_final[$], obs_perm[$];
  logic [191:0] exp_blk[$], obs_data[$];
  bit           exp_last[$], obs_last[$];
  int           obs_complete = 0;

  int perm_mode = 0;     // 0: identity permutation, 1: rotate + xor
  int perm_dly_max = 0;  // extra response delay of the permutation stand-in
  bit perm_hold = 0;
  bit perm_cancel = 0;

  task automatic chk(input bit ok, input string name, input logic [383:0] act,
                     input logic [383:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_eq(input string name, input logic [383:0] act, input logic [383:0] exp);
    chk(act === exp, name, act, exp);
  endtask

  task automatic step();
    @(posedge eph1);
    #2;
  endtask

  function automatic logic [383:0] rand384();
    logic [383:0] r;
    for (int i = 0; i < 12; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [383:0] perm_f(input logic [383:0] s);
    if (perm_mode == 0) return s;
    return {s[382:0], s[383]} ^ {12{32'h9E3779B9}};
  endfunction

  // Squeeze as a plain sequence of Up/Down steps on a 48-byte state.
  task automatic model_push(input logic [383:0] s, input int n, input logic [4:0] lb);
    logic [383:0] w;
    logic [191:0] blk, ones;
    int lbe;
    w = s;
    ones = '1;
    lbe = (lb == 0 || lb > 24) ? 24 : int'(lb);
    if (n > 0) begin
      w[7:0] = w[7:0] ^ 8'h40;
      for (int k = 1; k <= n; k++) begin
        exp_perm.push_back(w);
        w = perm_f(w);
        blk = w[383:192];
        if (k == n) blk = blk & ~(ones >> (8 * lbe));
        exp_blk.push_back(blk);
        exp_last.push_back(k == n);
        if (k < n) w[376] = ~w[376];
      end
    end
    exp_final.push_back(w);
  endtask

  // Permutation stand-in.
  initial begin
    logic [383:0] cap;
    int d;
    perm_done = 1'b0;
    permute_to_sqz = '0;
    forever begin
      step();
      if (perm_start && reset) begin
        cap = sqz_to_permute;
        d = $urandom_range(0, perm_dly_max);
        repeat (d) step();
        step();
        while (perm_hold) step();
        if (perm_cancel) perm_cancel = 0;
        else begin
          perm_done = 1'b1;
          permute_to_sqz = perm_f(cap);
          step();
          perm_done = 1'b0;
          permute_to_sqz = rand384();
        end
      end
    end
  end

  // Compare process: every cycle, against the model queues.
  bit           prev_v = 0, prev_r = 0, prev_l = 0, pend_sq = 0;
  logic [191:0] prev_d;
  logic [383:0] exp_sq;
  always @(negedge eph1) begin
    if (!reset) begin
      prev_v  = 0;
      pend_sq = 0;
    end else begin
      if (pend_sq) begin
        chk_eq("squeezed_state", squeezed_state, exp_sq);
        pend_sq = 0;
      end
      if (perm_start) begin
        obs_perm.push_back(sqz_to_permute);
        if (exp_perm.size() == 0) chk(0, "perm_start_unexpected", 1, 0);
        else chk_eq("perm_input", sqz_to_permute, exp_perm.pop_front());
      end
      if (sqz_valid) begin
        chk(busy, "busy_when_valid", busy, 1);
        if (prev_v && !prev_r)
          chk({sqz_data, sqz_last} === {prev_d, prev_l}, "stable_under_backpressure",
              {sqz_data, sqz_last}, {prev_d, prev_l});
        if (sqz_ready) begin
          obs_data.push_back(sqz_data);
          obs_last.push_back(sqz_last);
          if (exp_blk.size() == 0) chk(0, "block_unexpected", sqz_data, 0);
          else begin
            chk_eq("sqz_data", sqz_data, exp_blk.pop_front());
            chk_eq("sqz_last", sqz_last, exp_last.pop_front());
          end
        end
      end
      if (sqz_complete) begin
        obs_complete++;
        if (exp_final.size() == 0) chk(0, "complete_unexpected", 1, 0);
        else begin
          exp_sq = exp_final.pop_front();
          pend_sq = 1;
        end
      end
      prev_v = sqz_valid;
      prev_r = sqz_ready;
      prev_d = sqz_data;
      prev_l = sqz_last;
    end
  end

  task automatic clear_obs();
    obs_perm.delete();
    obs_data.delete();
    obs_last.delete();
    obs_complete = 0;
  endtask

  task automatic run_op(input logic [383:0] s, input int n, input logic [4:0] lb,
                        input bit bp, input bit rand_ready, input bit junk_start,
                        output int lat);
    bit done;
    int bp_phase, bp_cnt, bp_perm;
    bit bp_ok;
    logic [191:0] bp_data;
    clear_obs();
    model_push(s, n, lb);
    chk(!busy, "idle_before_start", busy, 0);
    state_in = s;
    sqz_blocks = 8'(n);
    sqz_last_bytes = lb;
    start = 1'b1;
    sqz_ready = bp ? 1'b0 : 1'b1;
    lat = 0;
    done = 0;
    bp_phase = 0;
    bp_cnt = 0;
    bp_perm = 0;
    bp_ok = 1;
    bp_data = '0;
    for (int c = 0; c < 20 * n + 40 && !done; c++) begin
      step();
      lat++;
      state_in = rand384();
      sqz_blocks = 8'($urandom);
      sqz_last_bytes = 5'($urandom);
      if (sqz_complete) begin
        done = 1;
        start = 1'b0;
      end else start = junk_start && ($urandom_range(0, 5) == 0);
      if (!bp) sqz_ready = rand_ready ? 1'($urandom) : 1'b1;
      else begin
        case (bp_phase)
          0: begin
            sqz_ready = 1'b0;
            if (sqz_valid) begin
              bp_data = sqz_data;
              bp_phase = 1;
            end
          end
          1: begin
            bp_cnt++;
            if (!sqz_valid || sqz_data !== bp_data) bp_ok = 0;
            if (perm_start) bp_perm++;
            if (bp_cnt == 10) begin
              chk(bp_ok, "bp_data_stable", sqz_data, bp_data);
              chk(bp_perm == 0, "bp_no_perm_start", bp_perm, 0);
              sqz_ready = 1'b1;
              bp_phase = 2;
            end
          end
          2: begin
            chk(!sqz_valid && obs_data.size() == 1, "bp_one_transfer",
                {sqz_valid, 8'(obs_data.size())}, {1'b0, 8'd1});
            bp_phase = 3;
          end
          default: sqz_ready = 1'b1;
        endcase
      end
    end
    if (!done) chk(0, "complete_timeout", 0, 1);
    start = 1'b0;
    sqz_ready = 1'b0;
    step();
  endtask

  initial begin
    int lat;
    logic [383:0] s;
    reset = 1'b0;
    start = 1'b0;
    sqz_blocks = '0;
    sqz_last_bytes = '0;
    state_in = '0;
    sqz_ready = 1'b0;
    repeat (3) step();
    chk({sqz_to_permute, perm_start, sqz_data, sqz_valid, sqz_last, squeezed_state,
         sqz_complete, busy} === '0, "reset_outputs_zero", {perm_start, sqz_valid, busy}, 0);
    reset = 1'b1;
    step();

    // One block, zero state, identity permute, minimum latency.
    perm_mode = 0;
    perm_dly_max = 0;
    run_op('0, 1, 5'd24, 0, 0, 0, lat);
    chk_eq("t1_perm_in_cu", obs_perm.size() > 0 ? obs_perm[0][7:0] : 8'hxx, 8'h40);
    chk_eq("t1_data", obs_data.size() > 0 ? obs_data[0] : 'x, 0);
    chk_eq("t1_last", obs_last.size() > 0 ? obs_last[0] : 1'bx, 1);
    chk_eq("t1_squeezed_lsb", squeezed_state[7:0], 8'h40);
    chk_eq("t1_complete_count", obs_complete, 1);
    chk_eq("t1_latency", lat, 4);

    // Three blocks: the Down pad shows up in block 2 and cancels in block 3.
    run_op('0, 3, 5'd24, 0, 0, 0, lat);
    chk_eq("t2_block_count", obs_data.size(), 3);
    if (obs_data.size() == 3) begin
      chk_eq("t2_blk1", obs_data[0], 0);
      chk_eq("t2_blk2", obs_data[1], 192'h1 << 184);
      chk_eq("t2_blk3", obs_data[2], 0);
      chk_eq("t2_lasts", {obs_last[0], obs_last[1], obs_last[2]}, 3'b001);
    end

    // Partial final block.
    run_op('1, 1, 5'd5, 0, 0, 0, lat);
    chk_eq("t3_partial", obs_data.size() > 0 ? obs_data[0] : 'x,
           {40'hFF_FFFF_FFFF, 152'h0});

    // Backpressure on the first of two blocks.
    perm_mode = 1;
    run_op(rand384(), 2, 5'd24, 1, 0, 0, lat);
    chk_eq("t4_block_count", obs_data.size(), 2);

    // Zero blocks: no permutation, no output, state passes straight through.
    s = rand384();
    run_op(s, 0, 5'd3, 0, 0, 0, lat);
    chk_eq("t5_latency", lat, 1);
    chk_eq("t5_no_perm", obs_perm.size(), 0);
    chk_eq("t5_no_valid", obs_data.size(), 0);
    chk_eq("t5_squeezed", squeezed_state, s);

    // Reset while waiting on the permutation, then a stray late perm_done.
    perm_hold = 1;
    s = rand384();
    model_push(s, 3, 5'd7);
    state_in = s;
    sqz_blocks = 8'd3;
    sqz_last_bytes = 5'd7;
    start = 1'b1;
    step();
    start = 1'b0;
    chk(perm_start, "t6_perm_start", perm_start, 1);
    repeat (3) step();
    reset = 1'b0;
    #1;
    chk({sqz_to_permute, perm_start, sqz_data, sqz_valid, sqz_last, squeezed_state,
         sqz_complete, busy} === '0, "t6_reset_abort_zero", {sqz_valid, busy}, 0);
    exp_perm.delete();
    exp_blk.delete();
    exp_last.delete();
    exp_final.delete();
    step();
    reset = 1'b1;
    perm_cancel = 1;
    perm_hold = 0;
    repeat (2) step();
    perm_done = 1'b1;
    permute_to_sqz = rand384();
    step();
    perm_done = 1'b0;
    repeat (2) step();
    chk({sqz_to_permute, perm_start, sqz_valid, sqz_last, sqz_complete, busy} === '0,
        "t6_late_done_ignored", {sqz_valid, busy}, 0);
    perm_dly_max = 3;
    run_op(rand384(), 2, 5'd10, 0, 1, 1, lat);
    chk_eq("t6_rerun_blocks", obs_data.size(), 2);

    // Randomized traffic: varying permute latency, ready, lengths, junk starts.
    for (int i = 0; i < 16; i++) begin
      perm_mode = $urandom_range(0, 1);
      run_op(rand384(), ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6),
             5'($urandom), 0, 1, 1, lat);
    end
    run_op(rand384(), 255, 5'($urandom), 0, 1, 1, lat);
    chk_eq("t7_max_blocks", obs_data.size(), 255);

    repeat (3) step();
    chk_eq("queues_drained", exp_perm.size() + exp_blk.size() + exp_final.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
